// File: rtl/axioma_intc_nested.sv
// rtl/axioma_intc_nested.sv - vectored fixed-priority interrupt controller with preemptive nesting
//
// Purpose: arbitrates NUM_SRC interrupt lines (edge-latched or level) into one
// vectored request to the CPU, keeps a stack of in-service sources so that only
// strictly higher-priority sources (lower index) may preempt, up to NEST_DEPTH levels.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   gie           global interrupt enable (CPU I-flag)
//   src           raw interrupt lines, synchronous to clk
//   src_mode      1 = rising-edge latched, 0 = level
//   src_en        per-source enable mask
//   flag_clr      write-1-to-clear pulses for edge flags
//   irq_ack       CPU accepts the current request
//   irq_reti      CPU returned from an interrupt
//   irq_req       request to CPU
//   irq_vector    vector of requested source (index + VEC_BASE)
//   flags         latched edge flags
//   in_service    at least one level in service
//   nest_level    current in-service depth
//   active_src    innermost in-service source, 31 when none
module axioma_intc_nested #(
  parameter int NUM_SRC    = 26,
  parameter int VEC_W      = 6,
  parameter int VEC_BASE   = 1,
  parameter int NEST_DEPTH = 4,
  localparam int LVL_W     = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               gie,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] src_mode,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic [NUM_SRC-1:0] flag_clr,
  input  logic               irq_ack,
  input  logic               irq_reti,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vector,
  output logic [NUM_SRC-1:0] flags,
  output logic               in_service,
  output logic [LVL_W-1:0]   nest_level,
  output logic [4:0]         active_src
);

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] flag_q, flag_d;
  logic [4:0]         stack_q [NEST_DEPTH];
  logic [4:0]         stack_d [NEST_DEPTH];
  logic [LVL_W-1:0]   depth_q, depth_d;
  logic [4:0]         sel_q, sel_d;
  logic               req_q, req_d;
  logic [VEC_W-1:0]   vec_q, vec_d;

  logic [NUM_SRC-1:0] rise, pending, ack_clr;
  logic [4:0]         top, cand;
  logic               cand_valid, pend_sel, sel_mode, arb_ok;

  assign rise    = src & ~src_prev_q & src_mode;
  assign pending = ((src_mode & flag_q) | (~src_mode & src)) & src_en;
  assign arb_ok  = gie && (depth_q < LVL_W'(NEST_DEPTH));
  // A new rise wins over any clear arriving in the same cycle.
  assign flag_d  = (flag_q & ~(flag_clr | ack_clr)) | rise;

  // Stack top, lowest-index eligible candidate, and status of the latched source.
  always_comb begin
    top        = 5'd31;
    cand       = 5'd0;
    cand_valid = 1'b0;
    pend_sel   = 1'b0;
    sel_mode   = 1'b0;
    for (int k = 0; k < NEST_DEPTH; k++) begin
      if (LVL_W'(k + 1) == depth_q) top = stack_q[k];
    end
    // Descending scan so the lowest index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i] && (depth_q == '0 || 5'(i) < top)) begin
        cand_valid = 1'b1;
        cand       = 5'(i);
      end
      if (sel_q == 5'(i)) begin
        pend_sel = pending[i];
        sel_mode = src_mode[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    stack_d = stack_q;
    sel_d   = sel_q;
    req_d   = req_q;
    vec_d   = vec_q;
    ack_clr = '0;
    case (state_q)
      IDLE, ACTIVE: begin
        if (state_q == ACTIVE && irq_reti) begin
          depth_d = depth_q - LVL_W'(1);
          if (depth_d == '0) state_d = IDLE;
        end else if (arb_ok && cand_valid) begin
          // In ACTIVE the threshold already limits cand to preempting sources.
          state_d = REQ;
          sel_d   = cand;
          req_d   = 1'b1;
          vec_d   = VEC_W'(cand) + VEC_W'(VEC_BASE);
        end
      end
      REQ: begin
        if (irq_ack) begin
          req_d = 1'b0;
          for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_mode && sel_q == 5'(i)) ack_clr[i] = 1'b1;
          end
          if (irq_reti) begin
            // Push then pop of the old top: sel replaces the top, depth unchanged.
            for (int k = 0; k < NEST_DEPTH; k++) begin
              if (LVL_W'(k + 1) == depth_q) stack_d[k] = sel_q;
            end
          end else begin
            for (int k = 0; k < NEST_DEPTH; k++) begin
              if (LVL_W'(k) == depth_q) stack_d[k] = sel_q;
            end
            depth_d = depth_q + LVL_W'(1);
          end
          state_d = (depth_d == '0) ? IDLE : ACTIVE;
        end else if (!gie || !pend_sel || irq_reti) begin
          req_d = 1'b0;
          if (irq_reti && depth_q != '0) depth_d = depth_q - LVL_W'(1);
          state_d = (depth_d == '0) ? IDLE : ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      src_prev_q <= '0;
      flag_q     <= '0;
      depth_q    <= '0;
      sel_q      <= '0;
      req_q      <= 1'b0;
      vec_q      <= '0;
      for (int k = 0; k < NEST_DEPTH; k++) stack_q[k] <= 5'd31;
    end else begin
      state_q    <= state_d;
      src_prev_q <= src;
      flag_q     <= flag_d;
      depth_q    <= depth_d;
      sel_q      <= sel_d;
      req_q      <= req_d;
      vec_q      <= vec_d;
      for (int k = 0; k < NEST_DEPTH; k++) stack_q[k] <= stack_d[k];
    end
  end

  assign irq_req    = req_q;
  assign irq_vector = vec_q;
  assign flags      = flag_q;
  assign nest_level = depth_q;
  assign in_service = (depth_q != '0);
  assign active_src = top;

endmodule

// File: tb/tb_axioma_intc_nested.sv
// tb/tb_axioma_intc_nested.sv - self-checking bench for axioma_intc_nested
module tb_axioma_intc_nested;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        gie, irq_ack, irq_reti;
  logic [25:0] src, src_mode, src_en, flag_clr;

  logic        req, ins;
  logic [5:0]  vec;
  logic [25:0] flg;
  logic [2:0]  lvl;
  logic [4:0]  act;

  logic        r1_req, r1_ins;
  logic [5:0]  r1_vec;
  logic [25:0] r1_flg;
  logic [0:0]  r1_lvl;
  logic [4:0]  r1_act;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axioma_intc_nested dut (
    .clk(clk), .reset_n(reset_n), .gie(gie), .src(src), .src_mode(src_mode),
    .src_en(src_en), .flag_clr(flag_clr), .irq_ack(irq_ack), .irq_reti(irq_reti),
    .irq_req(req), .irq_vector(vec), .flags(flg), .in_service(ins),
    .nest_level(lvl), .active_src(act)
  );

  axioma_intc_nested #(.NEST_DEPTH(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .gie(gie), .src(src), .src_mode(src_mode),
    .src_en(src_en), .flag_clr(flag_clr), .irq_ack(irq_ack), .irq_reti(irq_reti),
    .irq_req(r1_req), .irq_vector(r1_vec), .flags(r1_flg), .in_service(r1_ins),
    .nest_level(r1_lvl), .active_src(r1_act)
  );

  typedef struct {
    int          idx;
    logic [25:0] src;
    logic [25:0] clr;
    logic        gie;
    logic        ack;
    logic        reti;
    logic        e_req;
    logic [5:0]  e_vec;
    logic [25:0] e_flags;
    logic [2:0]  e_lvl;
    logic [4:0]  e_act;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic logic [25:0] b(int n);
    logic [25:0] one = 26'd1;
    return one << n;
  endfunction

  task automatic add(logic [25:0] s, logic [25:0] c, logic g, logic a, logic r,
                     logic er, logic [5:0] ev, logic [25:0] ef, logic [2:0] el,
                     logic [4:0] ea);
    vec_t v;
    v.idx = tbl.size(); v.src = s; v.clr = c; v.gie = g; v.ack = a; v.reti = r;
    v.e_req = er; v.e_vec = ev; v.e_flags = ef; v.e_lvl = el; v.e_act = ea;
    tbl.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] actual, logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Scoreboard: each table record is compared one cycle after being driven.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk($sformatf("v%0d_req", e.idx), 32'(req), 32'(e.e_req));
      if (e.e_req) chk($sformatf("v%0d_vec", e.idx), 32'(vec), 32'(e.e_vec));
      chk($sformatf("v%0d_flags", e.idx), 32'(flg), 32'(e.e_flags));
      chk($sformatf("v%0d_lvl", e.idx), 32'(lvl), 32'(e.e_lvl));
      chk($sformatf("v%0d_insvc", e.idx), 32'(ins), 32'(e.e_lvl != 3'd0));
      chk($sformatf("v%0d_act", e.idx), 32'(act), 32'(e.e_act));
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset_n = 1'b0; gie = 1'b0; irq_ack = 1'b0; irq_reti = 1'b0;
    src = '0; flag_clr = '0; src_en = '1;
    src_mode = ~b(7);
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_vec", 32'(vec), 0);
    chk("rst_flags", 32'(flg), 0);
    chk("rst_lvl", 32'(lvl), 0);
    chk("rst_insvc", 32'(ins), 0);
    chk("rst_act", 32'(act), 31);
    reset_n = 1'b1;

    //   src            clr    gie ack reti req vec flags          lvl act
    add(b(5),           0,     1,  0,  0,   0,  0,  b(5),          0,  31); // edge src5
    add(b(5),           0,     1,  0,  0,   1,  6,  b(5),          0,  31);
    add(0,              0,     1,  1,  0,   0,  0,  0,             1,  5);
    add(0,              0,     1,  0,  1,   0,  0,  0,             0,  31);
    add(b(3) | b(9),    0,     1,  0,  0,   0,  0,  b(3) | b(9),   0,  31); // 3 and 9 together
    add(0,              0,     1,  0,  0,   1,  4,  b(3) | b(9),   0,  31);
    add(0,              0,     1,  1,  0,   0,  0,  b(9),          1,  3);
    add(0,              0,     1,  0,  1,   0,  0,  b(9),          0,  31);
    add(0,              0,     1,  0,  0,   1,  10, b(9),          0,  31);
    add(0,              0,     1,  1,  0,   0,  0,  0,             1,  9);
    add(b(2),           0,     1,  0,  0,   0,  0,  b(2),          1,  9);  // preempt by src2
    add(0,              0,     1,  0,  0,   1,  3,  b(2),          1,  9);
    add(b(12),          0,     1,  1,  0,   0,  0,  b(12),         2,  2);
    add(0,              0,     1,  0,  0,   0,  0,  b(12),         2,  2);
    add(0,              0,     1,  0,  1,   0,  0,  b(12),         1,  9);
    add(0,              0,     1,  0,  0,   0,  0,  b(12),         1,  9);
    add(0,              0,     1,  0,  1,   0,  0,  b(12),         0,  31);
    add(0,              0,     1,  0,  0,   1,  13, b(12),         0,  31);
    add(0,              0,     1,  1,  0,   0,  0,  0,             1,  12);
    add(0,              0,     1,  0,  1,   0,  0,  0,             0,  31);
    add(b(7),           0,     1,  0,  0,   1,  8,  0,             0,  31); // level src7
    add(0,              0,     1,  0,  0,   0,  0,  0,             0,  31); // withdrawn
    add(0,              0,     1,  1,  1,   0,  0,  0,             0,  31); // stray ack/reti
    add(b(5),           b(5),  1,  0,  0,   0,  0,  b(5),          0,  31); // set beats clear
    add(0,              0,     1,  0,  0,   1,  6,  b(5),          0,  31);
    add(0,              0,     0,  0,  0,   0,  0,  b(5),          0,  31); // gie drop
    add(0,              0,     0,  0,  0,   0,  0,  b(5),          0,  31);
    add(0,              b(5),  1,  0,  0,   1,  6,  0,             0,  31);
    add(0,              0,     1,  0,  0,   0,  0,  0,             0,  31); // flag gone

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      src = tbl[i].src; flag_clr = tbl[i].clr; gie = tbl[i].gie;
      irq_ack = tbl[i].ack; irq_reti = tbl[i].reti;
      sb.push_back(tbl[i]);
    end
    @(negedge clk);
    src = '0; flag_clr = '0; irq_ack = 1'b0; irq_reti = 1'b0; gie = 1'b1;
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    // Reach depth 2 (src9 then src2), then reset mid-service.
    src = b(9);
    @(negedge clk); src = '0;
    @(negedge clk);
    chk("nest_req9", 32'(req), 1);
    chk("nest_vec9", 32'(vec), 10);
    irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0; src = b(2);
    @(negedge clk); src = '0;
    @(negedge clk);
    chk("nest_vec2", 32'(vec), 3);
    irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    chk("nest_lvl2", 32'(lvl), 2);
    chk("nest_act2", 32'(act), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(req), 0);
    chk("mid_rst_vec", 32'(vec), 0);
    chk("mid_rst_flags", 32'(flg), 0);
    chk("mid_rst_lvl", 32'(lvl), 0);
    chk("mid_rst_insvc", 32'(ins), 0);
    chk("mid_rst_act", 32'(act), 31);
    @(negedge clk); reset_n = 1'b1;

    // Single-level instance: no preemption while full.
    src = b(9);
    @(negedge clk); src = '0;
    @(negedge clk);
    chk("d1_req9", 32'(r1_req), 1);
    chk("d1_vec9", 32'(r1_vec), 10);
    irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    chk("d1_lvl1", 32'(r1_lvl), 1);
    chk("d1_act9", 32'(r1_act), 9);
    src = b(2);
    @(negedge clk); src = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("d1_noreq%0d", i), 32'(r1_req), 0);
    end
    chk("d1_flag2_kept", 32'(r1_flg), 32'(b(2)));
    irq_reti = 1'b1;
    @(negedge clk); irq_reti = 1'b0;
    chk("d1_lvl0", 32'(r1_lvl), 0);
    chk("d1_req_after_reti", 32'(r1_req), 0);
    @(negedge clk);
    chk("d1_req2", 32'(r1_req), 1);
    chk("d1_vec2", 32'(r1_vec), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
